branch_resolve: RTL

Execute-stage branch resolution unit, directly downstream of the branch comparator. It decodes the branch condition for the comparator (unsigned select), combines the comparator's equal/less-than flags with funct3 to decide taken/not-taken, and computes branch/JAL/JALR targets. Fetch always predicts not-taken, so every taken control transfer becomes a registered redirect request to fetch. The request is held until fetch accepts it, then wrong-path instructions are squashed for a fixed number of cycles.

---
 rtl/branch_resolve.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: decides taken/not-taken, computes targets,
// and issues a held redirect to fetch followed by a fixed-length squash window.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_imm,
  input  logic [31:0]      i_rs1,
  input  logic             i_brEq,
  input  logic             i_brLT,
  output logic             o_brUn,
  output logic             o_redir_valid,
  output logic [31:0]      o_redir_pc,
  input  logic             i_redir_ready,
  output logic             o_stall,
  output logic             o_flush,
  output logic [31:0]      o_link_pc,
  output logic             o_misalign,
  output logic             o_br_illegal,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_taken_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_SQUASH   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_sqCnt;
  logic [31:0]      r_redirPc;
  logic             r_misalign;
  logic             r_illegal;
  logic [CNT_W-1:0] r_brCount;
  logic [CNT_W-1:0] r_takenCount;

  logic             w_resolve;
  logic             w_condTaken;
  logic             w_taken;
  logic [31:0]      w_target;
  logic             w_enter;
  logic             w_misalign;
  logic             w_illegal;

  assign o_brUn    = i_funct3[1];
  assign o_link_pc = i_pc + 32'd4;

  // Inputs are only acted on in IDLE; REDIRECT/SQUASH treat EX as wrong-path.
  assign w_resolve = (r_state == S_IDLE) && i_valid &&
                     (i_is_branch || i_is_jal || i_is_jalr);

  always_comb begin
    w_condTaken = 1'b0;
    case (i_funct3)
      3'b000:          w_condTaken = i_brEq;
      3'b001:          w_condTaken = !i_brEq;
      3'b100, 3'b110:  w_condTaken = i_brLT;
      3'b101, 3'b111:  w_condTaken = !i_brLT;
      default:         w_condTaken = 1'b0;
    endcase
  end

  assign w_taken    = i_is_jalr || i_is_jal || (i_is_branch && w_condTaken);
  assign w_target   = i_is_jalr ? ((i_rs1 + i_imm) & 32'hFFFF_FFFE) : (i_pc + i_imm);
  assign w_misalign = w_resolve && w_taken && w_target[1];
  assign w_enter    = w_resolve && w_taken && !w_target[1];
  assign w_illegal  = w_resolve && !i_is_jalr && !i_is_jal &&
                      (i_funct3[2:1] == 2'b01);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_enter) w_next = S_REDIRECT;
      S_REDIRECT: if (i_redir_ready) w_next = S_SQUASH;
      S_SQUASH:   if (r_sqCnt == 4'd1) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_redir_valid = 1'b0;
    o_stall       = 1'b0;
    o_flush       = 1'b0;
    case (r_state)
      S_REDIRECT: begin
        o_redir_valid = 1'b1;
        o_stall       = 1'b1;
        o_flush       = 1'b1;
      end
      S_SQUASH: o_flush = 1'b1;
      default: ;
    endcase
  end

  // Squash counter: loaded on accept, counts the SQUASH cycles down to 1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sqCnt <= 4'd0;
    end else if (r_state == S_REDIRECT && i_redir_ready) begin
      r_sqCnt <= 4'(FLUSH_CYCLES);
    end else if (r_state == S_SQUASH) begin
      r_sqCnt <= r_sqCnt - 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_redirPc    <= 32'd0;
      r_misalign   <= 1'b0;
      r_illegal    <= 1'b0;
      r_brCount    <= '0;
      r_takenCount <= '0;
    end else begin
      r_misalign <= w_misalign;
      r_illegal  <= w_illegal;
      if (w_enter) begin
        r_redirPc    <= w_target;
        r_takenCount <= r_takenCount + CNT_W'(1);
      end
      if (w_resolve) begin
        r_brCount <= r_brCount + CNT_W'(1);
      end
    end
  end

  assign o_redir_pc    = r_redirPc;
  assign o_misalign    = r_misalign;
  assign o_br_illegal  = r_illegal;
  assign o_br_count    = r_brCount;
  assign o_taken_count = r_takenCount;

endmodule
